// File: rtl/latch_ctrl_pkg.sv
// Shared types and defaults for the latch write controller: state encoding,
// parameter defaults, counter width and a pointer-width helper.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int SETUP_CYC_DEF = 1;
  localparam int PULSE_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF  = 1;

  // All phase lengths are 1..15, so a 4-bit down-counter covers them.
  localparam int CNT_W = 4;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot winner selection. Priority starts at index ptr and wraps;
// with ptr tied to zero this is plain lowest-index-wins.
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_wr_ctrl.sv
// Serialises writes from NREQ requesters into one gated D-latch bank with
// setup / enable-pulse / hold timing. Define LATCH_WR_CTRL_RR_EN for
// round-robin arbitration; otherwise the lowest requesting index wins.
//
// state  | meaning
// IDLE   | no transaction; latch_d retains last value
// SETUP  | latch_d driven, latch_en low, SETUP_CYC cycles
// ENABLE | latch_en high, PULSE_CYC cycles
// HOLD   | latch_en low, latch_d still held, HOLD_CYC cycles
module latch_wr_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic                 latch_en,
  output logic [DW-1:0]        latch_d,
  output logic [NREQ-1:0]      done,
  output logic                 busy
);

  localparam int PW = ptr_w(NREQ);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NREQ-1:0]   gnt_nxt, done_nxt, win;
  logic              latch_en_nxt;
  logic [DW-1:0]     latch_d_nxt, win_data;
  logic [PW-1:0]     ptr;

`ifdef LATCH_WR_CTRL_RR_EN
  logic [PW-1:0]     ptr_nxt, win_idx;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) win_idx = PW'(i);
  end
`else
  assign ptr = '0;
`endif

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) win_data = win_data | wdata[i*DW +: DW];
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    gnt_nxt      = gnt;
    latch_en_nxt = latch_en;
    latch_d_nxt  = latch_d;
    done_nxt     = '0;
`ifdef LATCH_WR_CTRL_RR_EN
    ptr_nxt      = ptr;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt     = win;
          latch_d_nxt = win_data;
          cnt_nxt     = SETUP_LD;
          state_nxt   = SETUP;
`ifdef LATCH_WR_CTRL_RR_EN
          ptr_nxt     = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
`endif
        end
      end
      SETUP: begin
        if (cnt == CNT_TC) begin
          state_nxt    = ENABLE;
          cnt_nxt      = PULSE_LD;
          latch_en_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_TC;
        end
      end
      ENABLE: begin
        if (cnt == CNT_TC) begin
          state_nxt    = HOLD;
          cnt_nxt      = HOLD_LD;
          latch_en_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_TC;
        end
      end
      HOLD: begin
        // done is registered so it lines up with gnt dropping on the same edge
        if (cnt == CNT_TC) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          gnt_nxt   = '0;
          done_nxt  = gnt;
        end else begin
          cnt_nxt = cnt - CNT_TC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt      <= '0;
      latch_en <= 1'b0;
      latch_d  <= '0;
      done     <= '0;
`ifdef LATCH_WR_CTRL_RR_EN
      ptr      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      latch_en <= latch_en_nxt;
      latch_d  <= latch_d_nxt;
      done     <= done_nxt;
`ifdef LATCH_WR_CTRL_RR_EN
      ptr      <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// Self-checking bench for latch_wr_ctrl: a transaction-timeline model (grant
// edge plus phase offsets) checks every cycle under directed and random stimulus.
module tb_latch_wr_ctrl;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int S    = 1;
  localparam int P    = 2;
  localparam int H    = 1;
  localparam int T    = S + P + H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]    req = '0, req2 = '0;
  logic [NREQ*DW-1:0] wdata = '0, wdata2 = '0;
  logic [NREQ-1:0]    gnt, done, gnt2, done2;
  logic               latch_en, busy, latch_en2, busy2;
  logic [DW-1:0]      latch_d, latch_d2;

  int total = 0;
  int bad   = 0;

  // reference model: one transaction at a time, timed from its grant edge
  bit             m_active;
  int             m_phase;
  int             m_win;
  logic [DW-1:0]  m_d;
  logic [NREQ-1:0] m_done;
`ifdef LATCH_WR_CTRL_RR_EN
  int             m_ptr;
`endif

  latch_wr_ctrl #(.NREQ(NREQ), .DW(DW), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
    .latch_en(latch_en), .latch_d(latch_d), .done(done), .busy(busy)
  );

  latch_wr_ctrl #(.NREQ(NREQ), .DW(DW), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .wdata(wdata2), .gnt(gnt2),
    .latch_en(latch_en2), .latch_d(latch_d2), .done(done2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    int k;
    for (int i = 0; i < NREQ; i++) begin
`ifdef LATCH_WR_CTRL_RR_EN
      k = (m_ptr + i) % NREQ;
`else
      k = i;
`endif
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_phase  = 0;
    m_win    = 0;
    m_d      = '0;
    m_done   = '0;
`ifdef LATCH_WR_CTRL_RR_EN
    m_ptr    = 0;
`endif
  endtask

  task automatic model_step();
    m_done = '0;
    if (m_active) begin
      m_phase++;
      if (m_phase == T) begin
        m_active = 1'b0;
        m_done   = NREQ'(1) << m_win;
      end
    end else if (req != '0) begin
      m_win    = pick(req);
      m_active = 1'b1;
      m_phase  = 0;
      m_d      = wdata[m_win*DW +: DW];
`ifdef LATCH_WR_CTRL_RR_EN
      m_ptr    = (m_win + 1) % NREQ;
`endif
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NREQ-1:0] eg;
    eg = m_active ? (NREQ'(1) << m_win) : '0;
    check_val({tag, ".gnt"},  gnt, eg);
    check_val({tag, ".en"},   latch_en, (m_active && m_phase >= S && m_phase < S + P));
    check_val({tag, ".d"},    latch_d, m_d);
    check_val({tag, ".done"}, done, m_done);
    check_val({tag, ".busy"}, busy, m_active);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  // reset lands mid low-phase so its effect is seen before any clock edge
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit reached, saw_done;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    check_val("reset.gnt2", gnt2, 0);
    check_val("reset.en2", latch_en2, 0);
    rst = 1'b0;

    // single request from requester 1
    wdata = $urandom;
    wdata[15:8] = 8'hA5;
    req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      step("single");
      req = req & ~m_done;
    end
    check_val("single.d_kept", latch_d, 8'hA5);

    // all requesters held continuously
    req = 4'hF;
    for (int c = 0; c < 22; c++) begin
      wdata = $urandom;
      step("all");
    end
    req = '0;
    repeat (6) step("drain");

    // request dropped in SETUP and data changed in ENABLE are ignored
    wdata[15:8] = 8'h3C;
    req = 4'b0010;
    saw_done = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step("ignore");
      if (c == 0) req = '0;
      if (c == 1) wdata = $urandom;
      if (done[1]) saw_done = 1'b1;
    end
    check_val("ignore.d_orig", latch_d, 8'h3C);
    check_val("ignore.done_seen", saw_done, 1'b1);

    // reset in the middle of ENABLE, req0 still pending afterwards
    req = 4'b0001;
    reached = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step("pre_rst");
      if (m_active && m_phase == S) begin
        reached = 1'b1;
        break;
      end
    end
    check_val("rst.reach_enable", reached, 1'b1);
    check_val("rst.en_before", latch_en, 1'b1);
    async_reset("rst_mid");
    step("post_rst");
    check_val("rst.regrant", gnt, 4'b0001);
    req = '0;
    repeat (6) step("drain");

    // random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 15));
      wdata = $urandom;
      step("rand");
      if ($urandom_range(0, 2) == 0) req = req & ~m_done;
      if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
    end
    req = '0;
    repeat (6) step("drain");

    // non-default timing: SETUP 3, PULSE 1, HOLD 2
    wdata2 = 32'h0000_005A;
    req2 = 4'b0001;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("t2.en@%0d", e),   latch_en2, (e == 4));
      check_val($sformatf("t2.done@%0d", e), done2, (e == 7) ? 4'b0001 : 4'b0000);
      check_val($sformatf("t2.gnt@%0d", e),  gnt2, (e <= 6) ? 4'b0001 : 4'b0000);
      check_val($sformatf("t2.busy@%0d", e), busy2, (e <= 6));
      if (e == 1) begin
        req2 = '0;
        wdata2 = $urandom;
      end
    end
    check_val("t2.d", latch_d2, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
